// File: rtl/circuit_mavg_pkg.sv
// circuit_mavg_pkg: default geometry shared by the moving-average block and its interface.
// Rev 1.0
`default_nettype none

package circuit_mavg_pkg;

  localparam int C_W_DEFAULT     = 32;
  localparam int C_DEPTH_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/circuit_mavg_if.sv
// circuit_mavg_if: sample strobe/data in, moving sum/average/fill status out.
// Rev 1.0
`default_nettype none

interface circuit_mavg_if
  import circuit_mavg_pkg::*;
#(
  parameter int W     = C_W_DEFAULT,
  parameter int DEPTH = C_DEPTH_DEFAULT
);

  localparam int LD = $clog2(DEPTH);
  localparam int SW = W + LD;

  logic          en;
  logic          clr;
  logic [W-1:0]  x;
  logic [SW-1:0] y;
  logic [W-1:0]  avg;
  logic [LD:0]   cnt;
  logic          valid;

  modport master (
    output en, clr, x,
    input  y, avg, cnt, valid
  );

  modport slave (
    input  en, clr, x,
    output y, avg, cnt, valid
  );

endinterface

`default_nettype wire

// File: rtl/circuit_mavg_buf.sv
// circuit_mavg_buf: DEPTH x W sample ring, one write port and an asynchronous read at the same
// address; the read sees the pre-write contents. Rev 1.0
`default_nettype none

module circuit_mavg_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_addr,
  input  wire logic [W-1:0]             i_wdata,
  output logic      [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/circuit_mavg.sv
// circuit_mavg: running sum and average of the last DEPTH accepted samples.
// Rev 1.0
`default_nettype none

module circuit_mavg
  import circuit_mavg_pkg::*;
#(
  parameter int W     = C_W_DEFAULT,
  parameter int DEPTH = C_DEPTH_DEFAULT
) (
  input wire logic      clk,
  input wire logic      rst,
  circuit_mavg_if.slave bus
);

  localparam int LD = $clog2(DEPTH);
  localparam int SW = W + LD;
  localparam logic [LD:0] C_FULL = (LD + 1)'(DEPTH);

  logic [SW-1:0] r_y;
  logic [LD:0]   r_cnt;
  logic [LD-1:0] r_wp;

  logic          w_full;
  logic          w_we;
  logic [W-1:0]  w_oldest;
  logic [SW-1:0] w_old;
  logic [SW-1:0] w_y_nxt;

  assign w_full = (r_cnt == C_FULL);
  assign w_we   = rst & ~bus.clr & bus.en;

  circuit_mavg_buf #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_wp),
    .i_wdata (bus.x),
    .o_rdata (w_oldest)
  );

  // During fill the slot at wp is stale, so nothing leaves the window.
  assign w_old   = w_full ? {{LD{1'b0}}, w_oldest} : '0;
  assign w_y_nxt = r_y + {{LD{1'b0}}, bus.x} - w_old;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_y   <= '0;
      r_cnt <= '0;
      r_wp  <= '0;
    end else if (bus.clr) begin
      r_y   <= '0;
      r_cnt <= '0;
      r_wp  <= '0;
    end else if (bus.en) begin
      r_y  <= w_y_nxt;
      r_wp <= r_wp + 1'b1;
      if (!w_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.y     = r_y;
  assign bus.avg   = r_y[SW-1:LD];
  assign bus.cnt   = r_cnt;
  assign bus.valid = w_full;

endmodule

`default_nettype wire

// File: tb/tb_circuit_mavg.sv
// tb_circuit_mavg: directed vector table followed by random traffic against a queue-based window model.
// Rev 1.0
`default_nettype none

module tb_circuit_mavg;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int SW    = W + 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  circuit_mavg_if #(.W(W), .DEPTH(DEPTH)) bus ();

  circuit_mavg #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        en;
    logic [7:0]  x;
    int unsigned exp_y;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int unsigned win[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic [7:0] xv);
    @(negedge clk);
    rst     = r;
    bus.clr = c;
    bus.en  = e;
    bus.x   = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int unsigned ey, input int unsigned ec);
    chk({tag, ".y"},     32'(bus.y),     ey);
    chk({tag, ".avg"},   32'(bus.avg),   ey >> 2);
    chk({tag, ".cnt"},   32'(bus.cnt),   ec);
    chk({tag, ".valid"}, 32'(bus.valid), (ec == DEPTH) ? 1 : 0);
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic e, input logic [7:0] xv,
                              input int unsigned y, input int unsigned n);
    vec_t v;
    v.rst_n = r; v.clr = c; v.en = e; v.x = xv; v.exp_y = y; v.exp_cnt = n;
    return v;
  endfunction

  initial begin
    rst     = 1'b0;
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    bus.x   = '0;

    // reset with a live strobe
    vecs.push_back(mk(0, 0, 1, 55, 0, 0));
    vecs.push_back(mk(0, 0, 1, 55, 0, 0));
    // fill
    vecs.push_back(mk(1, 0, 1, 10, 10, 1));
    vecs.push_back(mk(1, 0, 1, 20, 30, 2));
    vecs.push_back(mk(1, 0, 1, 30, 60, 3));
    vecs.push_back(mk(1, 0, 1, 40, 100, 4));
    // slide and wrap, then idle
    vecs.push_back(mk(1, 0, 1, 50, 140, 4));
    vecs.push_back(mk(1, 0, 1, 60, 180, 4));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 8'hFF, 180, 4));
    // max values
    vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 255, 255, 1));
    vecs.push_back(mk(1, 0, 1, 255, 510, 2));
    vecs.push_back(mk(1, 0, 1, 255, 765, 3));
    vecs.push_back(mk(1, 0, 1, 255, 1020, 4));
    vecs.push_back(mk(1, 0, 1, 255, 1020, 4));
    // clear beats a simultaneous sample
    vecs.push_back(mk(1, 1, 1, 99, 0, 0));
    vecs.push_back(mk(1, 0, 1, 7, 7, 1));
    // refill to 180, then reset mid-window
    vecs.push_back(mk(1, 0, 1, 20, 27, 2));
    vecs.push_back(mk(1, 0, 1, 30, 57, 3));
    vecs.push_back(mk(1, 0, 1, 40, 97, 4));
    vecs.push_back(mk(1, 0, 1, 50, 140, 4));
    vecs.push_back(mk(1, 0, 1, 60, 180, 4));
    vecs.push_back(mk(0, 0, 1, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 5, 5, 1));
    vecs.push_back(mk(1, 0, 1, 6, 11, 2));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].clr, vecs[i].en, vecs[i].x);
      check_all($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_cnt);
    end

    // Random traffic: the window is simply the last DEPTH accepted samples.
    win.delete();
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r, c, e;
      logic [7:0] xv;
      int unsigned s;
      r  = ($urandom_range(0, 39) != 0);
      c  = ($urandom_range(0, 24) == 0);
      e  = ($urandom_range(0, 9) < 7);
      xv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(r, c, e, xv);
      if (!r || c) win.delete();
      else if (e) begin
        win.push_back(xv);
        if (win.size() > DEPTH) void'(win.pop_front());
      end
      s = 0;
      foreach (win[k]) s += win[k];
      check_all($sformatf("rnd%0d", i), s, win.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
